// File: rtl/mlp_div_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package mlp_div_pkg;
    localparam int DIN0_W  = 44;
    localparam int DIN1_W  = 28;
    localparam int DOUT_W  = 16;
    localparam int ITER    = 16;
    localparam int LATENCY = 17;
    localparam int CNT_W   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/mlp_sdiv_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module mlp_sdiv_step
    import mlp_div_pkg::*;
(
    input  logic [DIN1_W-1:0] rem_in,
    input  logic              bit_in,
    input  logic [DIN1_W-1:0] divisor,
    output logic [DIN1_W-1:0] rem_out,
    output logic              qbit
);
    logic [DIN1_W:0]   shifted;
    logic [DIN1_W+1:0] diff;

    // One extra bit beyond the shifted value so the borrow shows up as the sign.
    assign shifted = {rem_in, bit_in};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};
    assign qbit    = ~diff[DIN1_W+1];
    assign rem_out = qbit ? diff[DIN1_W-1:0] : shifted[DIN1_W-1:0];
endmodule

// File: rtl/mlp_sdiv_44s_28s_16_seq.sv
// Sequential 44/28 signed divider with a saturating 16-bit quotient and fixed 17-cycle latency.
module mlp_sdiv_44s_28s_16_seq
    import mlp_div_pkg::*;
#(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned din0_WIDTH = 32'd44,
    parameter int unsigned din1_WIDTH = 32'd28,
    parameter int unsigned dout_WIDTH = 32'd16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dz
);
    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic              accept, last_iter;
    logic [DIN0_W-1:0] amag;
    logic [DIN1_W-1:0] bmag;
    logic              preovf_in;

    logic              sign_a, sign_b, preovf_r, dz_r;
    logic [DIN1_W-1:0] bmag_r, pr, pr_nxt;
    logic [DOUT_W-1:0] alo, q;
    logic              qbit;

    logic              qneg, sat;
    logic [DOUT_W-1:0] qsig;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_iter = (cnt == CNT_W'(ITER - 1));

    assign amag = din0[DIN0_W-1] ? (~din0 + 1'b1) : din0;
    assign bmag = din1[DIN1_W-1] ? (~din1 + 1'b1) : din1;
    // Quotient would need more than 16 magnitude bits.
    assign preovf_in = (amag[DIN0_W-1:DOUT_W] >= bmag) && (din1 != '0);

    mlp_sdiv_step u_step (
        .rem_in  (pr),
        .bit_in  (alo[DOUT_W-1]),
        .divisor (bmag_r),
        .rem_out (pr_nxt),
        .qbit    (qbit)
    );

    always_ff @(posedge clk) begin
        if (reset)   state <= IDLE;
        else if (ce) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIN;
            FIN:     state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC) || (state == FIN);
        done = (state == DONE);
    end

    assign qneg = sign_a ^ sign_b;
    assign qsig = qneg ? (~q + 1'b1) : q;
    assign sat  = preovf_r || (!qneg && q[DOUT_W-1])
                           || ( qneg && q[DOUT_W-1] && (|q[DOUT_W-2:0]));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            dout     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            dz       <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            preovf_r <= 1'b0;
            dz_r     <= 1'b0;
            bmag_r   <= '0;
            pr       <= '0;
            alo      <= '0;
            q        <= '0;
        end else if (ce) begin
            if (accept) begin
                cnt      <= '0;
                sign_a   <= din0[DIN0_W-1];
                sign_b   <= din1[DIN1_W-1];
                preovf_r <= preovf_in;
                dz_r     <= (din1 == '0);
                bmag_r   <= bmag;
                pr       <= amag[DIN0_W-1:DOUT_W];
                alo      <= amag[DOUT_W-1:0];
                q        <= '0;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                pr  <= pr_nxt;
                alo <= {alo[DOUT_W-2:0], 1'b0};
                q   <= {q[DOUT_W-2:0], qbit};
            end else if (state == FIN) begin
                // Divide-by-zero saturates on the dividend sign alone.
                if (dz_r) begin
                    dout <= sign_a ? {1'b1, {(DOUT_W-1){1'b0}}} : {1'b0, {(DOUT_W-1){1'b1}}};
                    rem  <= '0;
                    ovf  <= 1'b0;
                    dz   <= 1'b1;
                end else if (sat) begin
                    dout <= qneg ? {1'b1, {(DOUT_W-1){1'b0}}} : {1'b0, {(DOUT_W-1){1'b1}}};
                    rem  <= '0;
                    ovf  <= 1'b1;
                    dz   <= 1'b0;
                end else begin
                    dout <= qsig;
                    rem  <= sign_a ? (~pr + 1'b1) : pr;
                    ovf  <= 1'b0;
                    dz   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mlp_sdiv_44s_28s_16_seq.sv
// Directed-vector bench for the sequential signed divider.
module tb_mlp_sdiv_44s_28s_16_seq;
    logic        clk = 1'b0;
    logic        reset, ce, start;
    logic [43:0] din0;
    logic [27:0] din1;
    logic        busy, done, ovf, dz;
    logic [15:0] dout;
    logic [27:0] rem;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mlp_sdiv_44s_28s_16_seq dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .rem   (rem),
        .ovf   (ovf),
        .dz    (dz)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation at the next edge; lat returns edges from accept to done.
    task automatic do_div(input logic [43:0] a, input logic [27:0] b,
                          input bit gap, input bit poke, output int lat);
        @(negedge clk);
        start = 1'b1; din0 = a; din1 = b;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 60) begin
            if (gap && lat == 5) begin
                ce = 1'b0;
                repeat (5) begin @(posedge clk); lat++; end
                @(negedge clk);
                ce = 1'b1;
            end
            start = poke && (lat == 3);
            if (start) begin din0 = 44'd5; din1 = 28'd1; end
            @(posedge clk); lat++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [15:0] eq, input logic [27:0] er,
                             input logic eo, input logic ez);
        chk({tag, ".dout"}, 64'(dout), 64'(eq));
        chk({tag, ".rem"},  64'(rem),  64'(er));
        chk({tag, ".ovf"},  64'(ovf),  64'(eo));
        chk({tag, ".dz"},   64'(dz),   64'(ez));
    endtask

    int lat;

    initial begin
        reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        check_res("rst", 16'd0, 28'd0, 1'b0, 1'b0);

        do_div(44'd100000, 28'd7, 0, 0, lat);
        chk("pos.lat", 64'(lat), 64'd17);
        check_res("pos", 16'd14285, 28'd5, 1'b0, 1'b0);

        do_div(44'(-100000), 28'd7, 0, 0, lat);
        chk("neg.lat", 64'(lat), 64'd17);
        check_res("neg", 16'(-14285), 28'(-5), 1'b0, 1'b0);

        do_div(44'd100000, 28'(-7), 0, 0, lat);
        check_res("negb", 16'(-14285), 28'd5, 1'b0, 1'b0);

        do_div(44'(-98304), 28'd3, 0, 0, lat);
        check_res("min", 16'h8000, 28'd0, 1'b0, 1'b0);

        do_div(44'd229369, 28'd7, 0, 0, lat);
        check_res("max", 16'd32767, 28'd0, 1'b0, 1'b0);

        do_div(44'd229376, 28'd7, 0, 0, lat);
        check_res("qovf", 16'd32767, 28'd0, 1'b1, 1'b0);

        do_div(44'd1000000, 28'd7, 0, 0, lat);
        chk("povf.lat", 64'(lat), 64'd17);
        check_res("povf", 16'd32767, 28'd0, 1'b1, 1'b0);

        do_div(44'h800_0000_0000, 28'd1, 0, 0, lat);
        check_res("nbig", 16'h8000, 28'd0, 1'b1, 1'b0);

        do_div(44'd100000, 28'd0, 0, 0, lat);
        chk("dzp.lat", 64'(lat), 64'd17);
        check_res("dzp", 16'd32767, 28'd0, 1'b0, 1'b1);

        do_div(44'(-5), 28'd0, 0, 0, lat);
        check_res("dzn", 16'h8000, 28'd0, 1'b0, 1'b1);

        // done held and outputs frozen while ce is low
        ce = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold.done", 64'(done), 64'd1);
        chk("hold.dout", 64'(dout), 64'h8000);
        ce = 1'b1;

        do_div(44'd100000, 28'd7, 1, 0, lat);
        chk("gap.lat", 64'(lat), 64'd22);
        check_res("gap", 16'd14285, 28'd5, 1'b0, 1'b0);

        do_div(44'(-100000), 28'd7, 0, 1, lat);
        chk("poke.lat", 64'(lat), 64'd17);
        check_res("poke", 16'(-14285), 28'(-5), 1'b0, 1'b0);

        // back-to-back: state is DONE here, the next start is accepted at once
        do_div(44'd1000, 28'd3, 0, 0, lat);
        chk("b2b.lat", 64'(lat), 64'd17);
        check_res("b2b", 16'd333, 28'd1, 1'b0, 1'b0);

        // reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; din0 = 44'd100000; din1 = 28'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid.busy0", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid.busy", 64'(busy), 64'd0);
        chk("mid.done", 64'(done), 64'd0);
        check_res("mid", 16'd0, 28'd0, 1'b0, 1'b0);

        do_div(44'd77777, 28'd11, 0, 0, lat);
        chk("post.lat", 64'(lat), 64'd17);
        check_res("post", 16'd7070, 28'd7, 1'b0, 1'b0);

        @(negedge clk);
        chk("post.done1", 64'(done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
